// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the two-source mux select arbiter.
package mux_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A         = 1'b0;
    localparam logic SEL_B         = 1'b1;
    localparam int   MAX_BURST_DEF = 8;
endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between the two sources, the downstream consumer and the arbiter.
interface mux_sel_arbiter_if;
    logic       req_a;
    logic       last_a;
    logic       req_b;
    logic       last_b;
    logic       out_ready;
    logic       sel;
    logic       gnt_a;
    logic       gnt_b;
    logic       out_valid;
    logic [7:0] beat_cnt;

    modport master (
        output req_a, last_a, req_b, last_b, out_ready,
        input  sel, gnt_a, gnt_b, out_valid, beat_cnt
    );

    modport slave (
        input  req_a, last_a, req_b, last_b, out_ready,
        output sel, gnt_a, gnt_b, out_valid, beat_cnt
    );
endinterface

// File: rtl/mux_sel_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot pick, prio breaks ties (0 prefers bit 0).
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] pick
);
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = prio ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
    end
endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the 2:1 mux select; holds sel for a packet and rotates
// on packet end, burst limit while the other side waits, or owner withdrawal.
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_sel_arbiter_if.slave   bus
);
    localparam logic [7:0] C_MAX8 = 8'(MAX_BURST);
    localparam logic [8:0] C_MAX9 = 9'(MAX_BURST);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_prio, w_prio_next;
    logic       r_sel, w_sel_next;
    logic       r_gnt_a, r_gnt_b;
    logic [7:0] r_beat_cnt, w_beat_cnt_next;

    logic       w_out_valid;
    logic       w_beat;
    logic       w_own_req, w_own_last, w_oth_req;
    logic [8:0] w_cnt_inc;
    logic       w_end;
    logic       w_regrant;
    logic [1:0] w_pick_req;
    logic [1:0] w_pick;

    assign w_out_valid = (r_gnt_a & bus.req_a) | (r_gnt_b & bus.req_b);
    assign w_beat      = w_out_valid & bus.out_ready;

    // At end-of-grant the current owner is masked out so only the other side can win.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_oth_req  = 1'b0;
        w_pick_req = {bus.req_b, bus.req_a};
        if (r_state == GNT_A) begin
            w_own_req  = bus.req_a;
            w_own_last = bus.last_a;
            w_oth_req  = bus.req_b;
            w_pick_req = {bus.req_b, 1'b0};
        end else if (r_state == GNT_B) begin
            w_own_req  = bus.req_b;
            w_own_last = bus.last_b;
            w_oth_req  = bus.req_a;
            w_pick_req = {1'b0, bus.req_a};
        end
    end

    rr_pick2 u_pick (
        .req  (w_pick_req),
        .prio (r_prio),
        .pick (w_pick)
    );

    // Saturated count still counts as "at limit" so a late requester can rotate in.
    assign w_cnt_inc = {1'b0, r_beat_cnt} + 9'd1;
    assign w_end     = (w_beat & w_own_last)
                     | (w_beat & (w_cnt_inc >= C_MAX9) & w_oth_req)
                     | ~w_own_req;
    assign w_regrant = (r_state == IDLE) | w_end;

    always_comb begin
        w_state_next    = r_state;
        w_prio_next     = r_prio;
        w_sel_next      = r_sel;
        w_beat_cnt_next = r_beat_cnt;
        if (w_regrant) begin
            w_beat_cnt_next = 8'd0;
            if (w_pick[0]) begin
                w_state_next = GNT_A;
                w_sel_next   = SEL_A;
                w_prio_next  = 1'b1;
            end else if (w_pick[1]) begin
                w_state_next = GNT_B;
                w_sel_next   = SEL_B;
                w_prio_next  = 1'b0;
            end else begin
                w_state_next = IDLE;
            end
        end else if (w_beat && (r_beat_cnt != C_MAX8)) begin
            w_beat_cnt_next = r_beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_sel      <= SEL_A;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_beat_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_prio     <= w_prio_next;
            r_sel      <= w_sel_next;
            r_gnt_a    <= (w_state_next == GNT_A);
            r_gnt_b    <= (w_state_next == GNT_B);
            r_beat_cnt <= w_beat_cnt_next;
        end
    end

    assign bus.sel       = r_sel;
    assign bus.gnt_a     = r_gnt_a;
    assign bus.gnt_b     = r_gnt_b;
    assign bus.beat_cnt  = r_beat_cnt;
    assign bus.out_valid = w_out_valid;
endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Two-requester round-robin arbiter that drives the select line of the 2:1 gate-level multiplexor (`multiplexor_2_1`) directly upstream of it. It grants source A or B for a packet, holds the select stable for the packet's beats, and handshakes beats to the consumer after the mux. Packets are bounded to `MAX_BURST` beats per grant when the other source is waiting.

## Interface
- `MAX_BURST`, default 8: beats allowed per grant before a forced rotation while the other source requests; legal range 1..255.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `req_a` input 1: source A has a beat available.
- `last_a` input 1: current A beat ends its packet; valid only with `req_a`.
- `req_b` input 1: source B has a beat available.
- `last_b` input 1: current B beat ends its packet; valid only with `req_b`.
- `out_ready` input 1: downstream consumer accepts the current beat.
- `sel` output 1: to the mux select input; 0 selects A, 1 selects B. Registered.
- `gnt_a` output 1: A is the granted owner. Registered.
- `gnt_b` output 1: B is the granted owner. Registered.
- `out_valid` output 1: combinational; `(gnt_a & req_a) | (gnt_b & req_b)`.
- `beat_cnt` output 8: beats accepted in the current grant. Registered.

## Operation
- Beat: `out_valid & out_ready` in a cycle; the granted source consumes its data on that edge.
- States:
  - IDLE: no grant.
  - GNT_A: `gnt_a=1`, `sel=0`.
  - GNT_B: `gnt_b=1`, `sel=1`.
- Priority pointer `prio`: 0 means A is preferred, 1 means B is preferred. On every grant the pointer moves to the other source.
- IDLE transitions:
  - Only `req_a` set: go to GNT_A.
  - Only `req_b` set: go to GNT_B.
  - Both set: grant per `prio`.
  - Neither set: stay in IDLE.
- GNT_X end-of-grant, where X is the owner and Y is the other source. The grant ends when any of these holds:
  - (a) a beat occurs with `last_X` set;
  - (b) a beat brings `beat_cnt+1 == MAX_BURST` while `req_Y` is set;
  - (c) `req_X` is low and no beat occurs.
- At end-of-grant:
  - If `req_Y` is set, go directly to GNT_Y with no idle cycle.
  - Otherwise go to IDLE.
- Rule (b) without `req_Y`: the grant continues. `beat_cnt` saturates at `MAX_BURST` and does not wrap.
- `beat_cnt`:
  - Increments on each beat.
  - Clears to 0 on any grant change or on entry to IDLE.
- `sel` changes only on a grant transition. In IDLE it holds its last value, so the mux output stays glitch-free.
- `last_X` outside a beat is ignored.
- Owner X must not be preempted mid-packet except by rule (b) or (c).

## Timing
- Reset (`rst_n=0` at a rising edge):
  - State IDLE, `prio=0`, `sel=0`.
  - `gnt_a=0`, `gnt_b=0`, `beat_cnt=0`.
  - `out_valid=0` as a consequence.
  - Reset mid-packet aborts the grant with no beat reported.
- Grant latency: request seen in IDLE at edge N gives `gnt` high after edge N. The earliest beat is in the cycle following edge N.
- Handover: the last beat of X at edge N gives `gnt_Y` and the new `sel` after edge N. The Y beat can occur in the next cycle. Throughput is 1 beat per cycle across handovers.
- `out_ready` low: the beat is stalled. State, `sel` and `beat_cnt` hold. `req_X`/`last_X` must be held by the source.
- Simultaneous `last_X` and rule (b) on the same beat: one rotation only.

## Structure
- Shared package `mux_pkg`:
  - State enum `arb_state_t` with values IDLE, GNT_A, GNT_B.
  - Constants `SEL_A=1'b0` and `SEL_B=1'b1`.
  - Default `MAX_BURST_DEF=8`.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker with inputs `req[1:0]` and `prio`, and outputs one-hot `pick`. It is used only in IDLE and at end-of-grant.
- Everything else is a single always block for state/`prio`/`beat_cnt`/outputs, plus one continuous assign for `out_valid`.

## Test plan
- Reset: hold `rst_n=0` 3 cycles with both reqs high → `sel=0`, `gnt_a=0`, `gnt_b=0`, `out_valid=0`, `beat_cnt=0`. After release, `gnt_a=1` one cycle later.
- Single packet: A sends 3 beats (`last_a` on the 3rd) with `out_ready=1` → `sel=0` throughout. `beat_cnt` goes 0,1,2. IDLE follows with `sel` held at 0.
- Contention and rotation: both request continuously, each packet 2 beats → grants alternate A,B,A,B with no idle cycles, and `sel` toggles every 2 beats.
- Burst limit: `MAX_BURST=4`, A streams 10 beats without `last_a` while B requests → A gets 4 beats, B gets its packet, then A resumes with `beat_cnt=0`. With B idle, A gets all 10 beats and `beat_cnt` saturates at 4.
- Backpressure: `out_ready=0` for 5 cycles mid-packet → `sel`, `gnt`, `beat_cnt` unchanged, and no rotation even though B is requesting.
- Abort: `req_a` drops mid-packet with `req_b=1` → GNT_B next edge. Also, `rst_n` pulsed mid-packet → reset values on the following cycle.
